// File: rtl/lfsr_if.sv
// Seed/output bundle for the lfsr block: the driver supplies seed, the register
// presents its current state on out.
interface lfsr_if #(
    parameter int unsigned WIDTH = 5
);
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] out;

    modport master (output seed, input  out);
    modport slave  (input  seed, output out);
endinterface

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR: loads seed under asynchronous reset, then shifts
// toward the MSB every clock with XOR-reduced tap feedback into bit 0.
module lfsr #(
    parameter int unsigned      WIDTH    = 5,
    parameter logic [WIDTH-1:0] TAPS     = 5'b10100,
    parameter logic [WIDTH-1:0] ZERO_SUB = 5'b00001
) (
    input  logic  clk,
    input  logic  rset,
    lfsr_if.slave bus
);
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] load_val;
    logic             fb;

    always_comb begin
        load_val = (bus.seed == '0) ? ZERO_SUB : bus.seed;
        fb       = ^(state & TAPS);
    end

    // A seed change while rset stays high is absorbed at the next clk edge,
    // since the reset branch also wins on every rising clk.
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state <= load_val;
        end else if (state == '0) begin
            state <= ZERO_SUB;
        end else begin
            state <= {state[WIDTH-2:0], fb};
        end
    end

    assign bus.out = state;
endmodule

// File: tb/tb_lfsr.sv
// Directed test of the 5-bit default lfsr: reset load, known step sequence,
// full period, zero-seed substitution, async reset and seed isolation.
module tb_lfsr;
    logic clk;
    logic rset;
    int unsigned n_checks;
    int unsigned n_errors;

    lfsr_if #(.WIDTH(5)) bus ();

    lfsr #(
        .WIDTH   (5),
        .TAPS    (5'b10100),
        .ZERO_SUB(5'b00001)
    ) dut (
        .clk (clk),
        .rset(rset),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: sim exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sequence after seed 00111, hand-derived from next = {q[3:0], q[4]^q[2]}
    logic [4:0] seq7 [8] = '{5'b01111, 5'b11111, 5'b11110, 5'b11100,
                             5'b11000, 5'b10001, 5'b00011, 5'b00110};

    logic [31:0] seen;
    logic [4:0]  v;
    int          first_ret;
    int          zero_hits;
    int          distinct;

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Known sequence from seed 00111
        rset     = 1'b1;
        bus.seed = 5'b00111;
        step();
        check("reset_load", bus.out, 5'b00111);
        rset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("seq7_%0d", i), bus.out, seq7[i]);
        end

        // Full period from 00001
        rset     = 1'b1;
        bus.seed = 5'b00001;
        step();
        check("period_load", bus.out, 5'b00001);
        rset      = 1'b0;
        seen      = '0;
        first_ret = -1;
        zero_hits = 0;
        for (int i = 1; i <= 31; i++) begin
            step();
            v = bus.out;
            if (v == 5'd0) zero_hits++;
            if (v == 5'b00001 && first_ret < 0) first_ret = i;
            seen[v] = 1'b1;
        end
        distinct = $countones(seen);
        check("period_len", first_ret, 31);
        check("period_distinct", distinct, 31);
        check("period_nozero", zero_hits, 0);

        // Zero seed substitution
        rset     = 1'b1;
        bus.seed = 5'b00000;
        step();
        check("zero_sub", bus.out, 5'b00001);
        rset = 1'b0;
        step();
        check("zero_next", bus.out, 5'b00010);

        // Async reset mid-run, 10 steps from 00111
        rset     = 1'b1;
        bus.seed = 5'b00111;
        step();
        rset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        bus.seed = 5'b10101;
        rset     = 1'b1;
        #1;
        check("async_now", bus.out, 5'b10101);
        step();
        step();
        check("async_hold", bus.out, 5'b10101);
        rset = 1'b0;
        step();
        check("async_release", bus.out, 5'b01010);

        // Seed changes while running are ignored
        rset     = 1'b1;
        bus.seed = 5'b00111;
        step();
        rset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.seed = 5'(i * 7 + 3);
            step();
            check($sformatf("seedign_%0d", i), bus.out, seq7[i]);
        end

        // Seed tracking while held in reset
        rset     = 1'b1;
        bus.seed = 5'b00111;
        step();
        check("track_a", bus.out, 5'b00111);
        bus.seed = 5'b11000;
        step();
        check("track_b", bus.out, 5'b11000);
        rset = 1'b0;
        step();
        check("track_release", bus.out, 5'b10001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
